score_display_scanner: RTL and testbench

//  Parametrised successor to the 2-digit score display: shows two player scores as

---
 rtl/score_display_scanner.sv | 187 ++++++++++++++++++
 tb/tb_score_display_scanner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/score_display_scanner.sv
// Two-player decimal score display: scans a multiplexed active-low 7-segment bank,
// converting once-per-frame score snapshots with a sequential double-dabble unit.
module score_display_scanner #(
  parameter int SCORE_W           = 7,
  parameter int DIGITS_PER_PLAYER = 2,
  parameter int REFRESH_DIV       = 100000,
  parameter int BLANK_CYC         = 2000,
  parameter int BLINK_TICKS       = 128
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SCORE_W-1:0]               p1_score,
  input  logic [SCORE_W-1:0]               p2_score,
  input  logic [1:0]                       winner,
  output logic [6:0]                       seg,
  output logic [2*DIGITS_PER_PLAYER-1:0]   an
);
  localparam int DPP        = DIGITS_PER_PLAYER;
  localparam int NUM_DIGITS = 2 * DPP;
  localparam int BCD_W      = 4 * DPP;
  localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int BLK_W      = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int BIT_W      = $clog2(SCORE_W + 1);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      DPP_IDX   = IDX_W'(DPP);
  localparam logic [BLK_W-1:0]      BLK_LAST  = BLK_W'(BLINK_TICKS - 1);
  localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(SCORE_W - 1);
  localparam logic [31:0]           MAX_SCORE = 32'(10 ** DPP - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DPP; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [BLK_W-1:0]   blk_cnt_r;
  logic               blink_on_r;
  conv_state_t        state_r;
  logic [BIT_W-1:0]   bit_r;
  logic [SCORE_W-1:0] p1_bin_r, p2_bin_r;
  logic [BCD_W-1:0]   p1_work_r, p2_work_r, p1_bcd_r, p2_bcd_r;
  logic               p1_sat_work_r, p2_sat_work_r, p1_sat_r, p2_sat_r;

  logic               tick_s, frame_start_s;
  logic [BCD_W-1:0]   p1_adj_s, p2_adj_s, sel_bcd_s;
  logic               sel_sat_s, sel_p1_s, lz_s, higher_zero_s, hide_s;
  logic [IDX_W-1:0]   sel_pos_s;
  logic [3:0]         digit_s;

  assign tick_s        = (cnt_r == CNT_LAST);
  assign frame_start_s = tick_s && (idx_r == IDX_LAST);
  assign p1_adj_s      = add3(p1_work_r);
  assign p2_adj_s      = add3(p2_work_r);

  // Refresh counter, digit slot index and blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= '0;
      idx_r      <= '0;
      blk_cnt_r  <= '0;
      blink_on_r <= 1'b1;
    end else if (tick_s) begin
      cnt_r <= '0;
      idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
      if (blk_cnt_r == BLK_LAST) begin
        blk_cnt_r  <= '0;
        blink_on_r <= ~blink_on_r;
      end else begin
        blk_cnt_r <= blk_cnt_r + BLK_W'(1);
      end
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Double-dabble converter; saturation is flagged at capture so BCD only needs DPP digits
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      bit_r         <= '0;
      p1_bin_r      <= '0;
      p2_bin_r      <= '0;
      p1_work_r     <= '0;
      p2_work_r     <= '0;
      p1_sat_work_r <= 1'b0;
      p2_sat_work_r <= 1'b0;
      p1_bcd_r      <= '0;
      p2_bcd_r      <= '0;
      p1_sat_r      <= 1'b0;
      p2_sat_r      <= 1'b0;
    end else if (frame_start_s) begin
      state_r       <= SHIFT;
      bit_r         <= '0;
      p1_bin_r      <= p1_score;
      p2_bin_r      <= p2_score;
      p1_work_r     <= '0;
      p2_work_r     <= '0;
      p1_sat_work_r <= (32'(p1_score) > MAX_SCORE);
      p2_sat_work_r <= (32'(p2_score) > MAX_SCORE);
    end else begin
      case (state_r)
        IDLE: state_r <= IDLE;
        SHIFT: begin
          {p1_work_r, p1_bin_r} <= {p1_adj_s[BCD_W-2:0], p1_bin_r, 1'b0};
          {p2_work_r, p2_bin_r} <= {p2_adj_s[BCD_W-2:0], p2_bin_r, 1'b0};
          if (bit_r == BIT_LAST) state_r <= COMMIT;
          else                   bit_r   <= bit_r + BIT_W'(1);
        end
        COMMIT: begin
          p1_bcd_r <= p1_work_r;
          p2_bcd_r <= p2_work_r;
          p1_sat_r <= p1_sat_work_r;
          p2_sat_r <= p2_sat_work_r;
          state_r  <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Select the current digit, resolve saturation, leading-zero blanking and blink
  always_comb begin
    sel_bcd_s     = p2_bcd_r;
    sel_sat_s     = p2_sat_r;
    sel_p1_s      = 1'b0;
    sel_pos_s     = idx_r;
    lz_s          = 1'b0;
    higher_zero_s = 1'b1;
    if (idx_r >= DPP_IDX) begin
      sel_bcd_s = p1_bcd_r;
      sel_sat_s = p1_sat_r;
      sel_p1_s  = 1'b1;
      sel_pos_s = idx_r - DPP_IDX;
    end else begin
      sel_p1_s  = 1'b0;
    end
    digit_s = sel_sat_s ? 4'd9 : sel_bcd_s[{sel_pos_s, 2'b00} +: 4];
    for (int j = DPP - 1; j >= 1; j--) begin
      higher_zero_s = higher_zero_s && (sel_bcd_s[4*j +: 4] == 4'd0);
      if (j == int'(sel_pos_s) && higher_zero_s && !sel_sat_s) lz_s = 1'b1;
      else                                                     lz_s = lz_s;
    end
    hide_s = !blink_on_r && (sel_p1_s ? winner[1] : winner[0]);
  end

  // Registered segment/anode drive
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= 7'b1111111;
    end else if (cnt_r < BLANK_END || hide_s) begin
      an  <= '1;
      seg <= 7'b1111111;
    end else begin
      an  <= ~(AN_ONE << idx_r);
      seg <= lz_s ? 7'b1111111 : glyph(digit_s);
    end
  end
endmodule

// File: tb/tb_score_display_scanner.sv
// Directed self-checking bench for score_display_scanner (REFRESH_DIV=8, BLANK_CYC=1,
// BLINK_TICKS=4). After N post-reset edges the outputs show slot (N-1)/8, count (N-1)%8.
module tb_score_display_scanner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] p1_score = 7'd0;
  logic [6:0] p2_score = 7'd0;
  logic [1:0] winner = 2'b00;
  logic [6:0] seg;
  logic [3:0] an;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  score_display_scanner #(
    .SCORE_W(7), .DIGITS_PER_PLAYER(2), .REFRESH_DIV(8), .BLANK_CYC(1), .BLINK_TICKS(4)
  ) dut (
    .clk(clk), .rst(rst), .p1_score(p1_score), .p2_score(p2_score),
    .winner(winner), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic start(input logic [6:0] p1, input logic [6:0] p2, input logic [1:0] w);
    rst = 1'b1; p1_score = p1; p2_score = p2; winner = w;
    repeat (5) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
    end
  endtask

  task automatic test_reset();
    int        cy[5]   = '{1, 2, 12, 20, 28};
    logic [3:0] ean[5]  = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] eseg[5] = '{7'b1111111, 7'b1000000, 7'b1111111, 7'b1000000, 7'b1111111};
    rst = 1'b1; p1_score = 7'd0; p2_score = 7'd0; winner = 2'b00;
    repeat (5) @(negedge clk);
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_hold: an=%b seg=%b, required 1111/1111111", an, seg);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_cyc(cy[i]);
      checks++;
      if (an !== ean[i] || (i > 0 && seg !== eseg[i])) begin
        errors++;
        $display("FAIL reset_display[%0d]: an=%b seg=%b, required %b/%b", i, an, seg, ean[i], eseg[i]);
      end
    end
  endtask

  task automatic test_scores();
    int        cy[6]   = '{36, 41, 44, 52, 60, 68};
    logic [3:0] ean[6]  = '{4'b1110, 4'b1111, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] eseg[6] = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b0100100, 7'b0011001, 7'b0010010};
    start(7'd42, 7'd5, 2'b00);
    for (int i = 0; i < 6; i++) begin
      wait_cyc(cy[i]);
      checks++;
      if (an !== ean[i] || (i != 1 && seg !== eseg[i])) begin
        errors++;
        $display("FAIL scores_42_5[%0d]: an=%b seg=%b, required %b/%b", i, an, seg, ean[i], eseg[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] ean[4]  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] eseg_b[4] = '{7'b1111111, 7'b0010000, 7'b0010000, 7'b0010000};
    start(7'd120, 7'd99, 2'b00);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(8 * (i + 5) + 4);
      checks++;
      if (an !== ean[i] || seg !== 7'b0010000) begin
        errors++;
        $display("FAIL saturate_120_99[%0d]: an=%b seg=%b, required %b/0010000", i, an, seg, ean[i]);
      end
    end
    // 100 is the first saturating value; P2=9 has a blanked tens digit
    start(7'd100, 7'd9, 2'b00);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(8 * (i + 5) + 4);
      checks++;
      if (an !== ean[i] || seg !== eseg_b[i]) begin
        errors++;
        $display("FAIL saturate_100_9[%0d]: an=%b seg=%b, required %b/%b", i, an, seg, ean[i], eseg_b[i]);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    int        cy[4]   = '{68, 72, 84, 100};
    logic [3:0] ean[4]  = '{4'b1110, 4'b1110, 4'b1011, 4'b1110};
    logic [6:0] eseg[4] = '{7'b0010010, 7'b0010010, 7'b0100100, 7'b1111000};
    start(7'd42, 7'd5, 2'b00);
    wait_cyc(52);
    p2_score = 7'd7;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(cy[i]);
      checks++;
      if (an !== ean[i] || seg !== eseg[i]) begin
        errors++;
        $display("FAIL mid_frame_change[%0d]: an=%b seg=%b, required %b/%b", i, an, seg, ean[i], eseg[i]);
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] ean[8] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111,
                           4'b1110, 4'b1101, 4'b1111, 4'b1111};
    start(7'd42, 7'd5, 2'b10);
    for (int i = 0; i < 8; i++) begin
      wait_cyc(8 * (i + 8) + 4);
      checks++;
      if (an !== ean[i]) begin
        errors++;
        $display("FAIL blink_p1_slot%0d: an=%b, required %b", i + 8, an, ean[i]);
      end
    end
    wait_cyc(164);
    checks++;
    if (an !== 4'b1110) begin
      errors++;
      $display("FAIL blink_p2_steady: an=%b, required 1110", an);
    end
    winner = 2'b11;
    wait_cyc(165);
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL blink_both: an=%b, required 1111", an);
    end
    winner = 2'b00;
    wait_cyc(180);
    checks++;
    if (an !== 4'b1011 || seg !== 7'b0100100) begin
      errors++;
      $display("FAIL blink_off_steady: an=%b seg=%b, required 1011/0100100", an, seg);
    end
  endtask

  task automatic test_reset_mid_shift();
    int        cy[6]   = '{4, 20, 28, 36, 52, 68};
    logic [3:0] ean[6]  = '{4'b1110, 4'b1011, 4'b0111, 4'b1110, 4'b1011, 4'b1110};
    logic [6:0] eseg[6] = '{7'b1000000, 7'b1000000, 7'b1111111, 7'b1000000, 7'b0100100, 7'b0010010};
    start(7'd42, 7'd5, 2'b00);
    wait_cyc(60);
    checks++;
    if (an !== 4'b0111 || seg !== 7'b0011001) begin
      errors++;
      $display("FAIL pre_reset_display: an=%b seg=%b, required 0111/0011001", an, seg);
    end
    wait_cyc(67);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_cyc(cy[i]);
      checks++;
      if (an !== ean[i] || seg !== eseg[i]) begin
        errors++;
        $display("FAIL reset_mid_shift[%0d]: an=%b seg=%b, required %b/%b", i, an, seg, ean[i], eseg[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scores();
    test_saturate();
    test_mid_frame_change();
    test_blink();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
